// File: rtl/smi_responder_pkg.sv
// Shared SMI responder definitions: opcodes, status codes, header field offsets, FSM states.
// Header layout: [7:0] opcode/status, [15:8] length in words, [31:16] zero, [63:32] tag.
package smi_responder_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic [7:0] ST_OK        = 8'h00;
  localparam logic [7:0] ST_BAD_OP    = 8'h01;
  localparam logic [7:0] ST_BAD_RANGE = 8'h02;
  localparam logic [7:0] ST_BAD_FRAME = 8'h03;

  localparam int HDR_OP_LSB  = 0;
  localparam int HDR_LEN_LSB = 8;
  localparam int HDR_TAG_LSB = 32;

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_DRAIN,
    S_RHDR,
    S_RDATA
  } state_e;

  function automatic logic [63:0] make_hdr(input logic [7:0] status,
                                           input logic [7:0] len,
                                           input logic [31:0] tag);
    return {tag, 16'h0000, len, status};
  endfunction

endpackage

// File: rtl/smi_responder_ram.sv
// Single-port synchronous RAM, DataWidth x 2^AddrWidth, one-cycle read latency.
// Write-first: a write cycle returns the written word on rdata the next cycle. Contents are never reset.
module smi_responder_ram #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem_q [2**AddrWidth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
      rdata_q     <= wdata;
    end else begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/smi_transaction_responder.sv
// SMI memory target: one request frame in, one response frame out; response header 1 cycle after the last request flit.
// Reads stream back-to-back via prefetch + 2-entry skid. Optional counters under SMI_RESPONDER_STATS_EN.
module smi_transaction_responder
  import smi_responder_pkg::*;
#(
  parameter int FlitWidth = 8,
  parameter int DataWidth = FlitWidth*8,
  parameter int AddrWidth = 10,
  parameter int MaxBurst  = 16
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 smiReqInReady,
  input  logic [7:0]           smiReqInEofc,
  input  logic [DataWidth-1:0] smiReqInData,
  output logic                 smiReqInStop,
  output logic                 smiRespOutReady,
  output logic [7:0]           smiRespOutEofc,
  output logic [DataWidth-1:0] smiRespOutData,
  input  logic                 smiRespOutStop
`ifdef SMI_RESPONDER_STATS_EN
  ,
  output logic [31:0]          statReadCount,
  output logic [31:0]          statWriteCount,
  output logic [31:0]          statErrorCount
`endif
);

  localparam logic [7:0] EofcLast = 8'(FlitWidth);

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d, len_q, len_d, status_q, status_d;
  logic [7:0]           idx_q, idx_d, ld_cnt_q, ld_cnt_d;
  logic [31:0]          tag_q, tag_d;
  logic [AddrWidth-1:0] addr_q, addr_d, flit_addr, ram_addr;
  logic [AddrWidth:0]   range_end;
  logic                 rd_pend_q, rd_pend_d;
  logic [DataWidth-1:0] skid_q [2];
  logic [DataWidth-1:0] skid_d [2];
  logic                 skid_wp_q, skid_wp_d, skid_rp_q, skid_rp_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;
  logic                 resp_vld_q, resp_vld_d;
  logic [7:0]           resp_eofc_q, resp_eofc_d;
  logic [DataWidth-1:0] resp_dat_q, resp_dat_d;
  logic                 ram_we;
  logic [DataWidth-1:0] ram_rdata, head;
  logic                 req_xfer, resp_xfer, req_eof, rd_ok, go_rhdr, word_load, avail;
  logic                 push, consume_skid, consume_ram, issue;
  logic [7:0]           st;

  assign smiReqInStop    = srst | (state_q == S_RHDR) | (state_q == S_RDATA);
  assign req_xfer        = smiReqInReady & ~smiReqInStop;
  assign req_eof         = smiReqInEofc != 8'h00;
  assign resp_xfer       = resp_vld_q & ~smiRespOutStop;
  assign rd_ok           = (opcode_q == OP_READ) && (status_q == ST_OK);
  assign flit_addr       = smiReqInData[AddrWidth+2:3];
  assign range_end       = {1'b0, flit_addr} + (AddrWidth+1)'(len_q);
  assign avail           = (skid_cnt_q != 2'd0) | rd_pend_q;
  assign head            = (skid_cnt_q != 2'd0) ? skid_q[skid_rp_q] : ram_rdata;
  assign smiRespOutReady = resp_vld_q;
  assign smiRespOutEofc  = resp_eofc_q;
  assign smiRespOutData  = resp_dat_q;

  smi_responder_ram #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(smiReqInData),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    len_d       = len_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    ld_cnt_d    = ld_cnt_q;
    rd_pend_d   = 1'b0;
    skid_d      = skid_q;
    skid_wp_d   = skid_wp_q;
    skid_rp_d   = skid_rp_q;
    resp_vld_d  = resp_vld_q;
    resp_eofc_d = resp_eofc_q;
    resp_dat_d  = resp_dat_q;
    ram_we      = 1'b0;
    ram_addr    = addr_q + AddrWidth'(idx_q);
    go_rhdr     = 1'b0;
    word_load   = 1'b0;
    st          = status_q;

    unique case (state_q)
      S_HDR: if (req_xfer) begin
        opcode_d = smiReqInData[HDR_OP_LSB +: 8];
        len_d    = smiReqInData[HDR_LEN_LSB +: 8];
        tag_d    = smiReqInData[HDR_TAG_LSB +: 32];
        idx_d    = 8'd0;
        ld_cnt_d = 8'd0;
        if (req_eof) begin
          st      = ST_BAD_FRAME;
          go_rhdr = 1'b1;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: if (req_xfer) begin
        addr_d = flit_addr;
        if (opcode_q != OP_READ && opcode_q != OP_WRITE) st = ST_BAD_OP;
        else if (len_q == 8'd0 || len_q > 8'(MaxBurst) ||
                 range_end > {1'b1, {AddrWidth{1'b0}}}) st = ST_BAD_RANGE;
        else if (opcode_q == OP_READ) st = req_eof ? ST_OK : ST_BAD_FRAME;
        else st = req_eof ? ST_BAD_FRAME : ST_OK;
        if (req_eof) go_rhdr = 1'b1;
        else if (st == ST_OK) state_d = S_WDATA;
        else state_d = S_DRAIN;
        // Prefetch word 0 so it is ready behind the response header.
        if (opcode_q == OP_READ && st == ST_OK) begin
          ram_addr  = flit_addr;
          rd_pend_d = 1'b1;
          idx_d     = 8'd1;
        end
      end
      S_WDATA: if (req_xfer) begin
        if (idx_q < len_q) begin
          ram_we  = 1'b1;
          idx_d   = idx_q + 8'd1;
          st      = (idx_q + 8'd1 == len_q) ? ST_OK : ST_BAD_FRAME;
          go_rhdr = req_eof;
        end else begin
          st = ST_BAD_FRAME;
          if (req_eof) go_rhdr = 1'b1;
          else state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (req_xfer && req_eof) go_rhdr = 1'b1;
      S_RHDR: if (resp_xfer) begin
        if (rd_ok) begin
          state_d   = S_RDATA;
          word_load = avail;
        end else begin
          state_d = S_HDR;
        end
      end
      S_RDATA: begin
        if (resp_xfer && resp_eofc_q != 8'h00) state_d = S_HDR;
        else if ((!resp_vld_q || resp_xfer) && ld_cnt_q < len_q) word_load = avail;
      end
      default: state_d = S_HDR;
    endcase

    if (resp_xfer) resp_vld_d = 1'b0;
    if (go_rhdr) begin
      state_d     = S_RHDR;
      resp_vld_d  = 1'b1;
      resp_eofc_d = (opcode_d == OP_READ && st == ST_OK) ? 8'h00 : EofcLast;
      resp_dat_d  = DataWidth'(make_hdr(st, len_d, tag_d));
    end
    if (word_load) begin
      resp_vld_d  = 1'b1;
      resp_dat_d  = head;
      resp_eofc_d = (ld_cnt_q + 8'd1 == len_q) ? EofcLast : 8'h00;
      ld_cnt_d    = ld_cnt_q + 8'd1;
    end
    status_d = st;

    // Skid accounting: a new read issues only if the word in flight will still have a slot.
    consume_skid = word_load && (skid_cnt_q != 2'd0);
    consume_ram  = word_load && (skid_cnt_q == 2'd0);
    push         = rd_pend_q && !consume_ram;
    if (push) begin
      skid_d[skid_wp_q] = ram_rdata;
      skid_wp_d         = ~skid_wp_q;
    end
    if (consume_skid) skid_rp_d = ~skid_rp_q;
    skid_cnt_d = skid_cnt_q + 2'(push) - 2'(consume_skid);
    issue = ((state_q == S_RHDR && rd_ok) || state_q == S_RDATA) &&
            (idx_q < len_q) && (skid_cnt_d <= 2'd1);
    if (issue) begin
      rd_pend_d = 1'b1;
      idx_d     = idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_HDR;
      resp_vld_q  <= 1'b0;
      resp_eofc_q <= 8'h00;
      resp_dat_q  <= '0;
      rd_pend_q   <= 1'b0;
      skid_cnt_q  <= 2'd0;
      skid_wp_q   <= 1'b0;
      skid_rp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_vld_q  <= resp_vld_d;
      resp_eofc_q <= resp_eofc_d;
      resp_dat_q  <= resp_dat_d;
      rd_pend_q   <= rd_pend_d;
      skid_cnt_q  <= skid_cnt_d;
      skid_wp_q   <= skid_wp_d;
      skid_rp_q   <= skid_rp_d;
    end
  end

  always_ff @(posedge clk) begin
    opcode_q <= opcode_d;
    len_q    <= len_d;
    tag_q    <= tag_d;
    addr_q   <= addr_d;
    idx_q    <= idx_d;
    ld_cnt_q <= ld_cnt_d;
    status_q <= status_d;
    skid_q   <= skid_d;
  end

`ifdef SMI_RESPONDER_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d, stat_err_q, stat_err_d;
  logic        hdr_xfer;

  assign hdr_xfer = (state_q == S_RHDR) && resp_xfer;

  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (hdr_xfer) begin
      if (status_q != ST_OK) begin
        if (stat_err_q != 32'hFFFF_FFFF) stat_err_d = stat_err_q + 32'd1;
      end else if (opcode_q == OP_READ) begin
        if (stat_rd_q != 32'hFFFF_FFFF) stat_rd_d = stat_rd_q + 32'd1;
      end else if (stat_wr_q != 32'hFFFF_FFFF) begin
        stat_wr_d = stat_wr_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      stat_rd_q  <= 32'd0;
      stat_wr_q  <= 32'd0;
      stat_err_q <= 32'd0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign statReadCount  = stat_rd_q;
  assign statWriteCount = stat_wr_q;
  assign statErrorCount = stat_err_q;
`endif

endmodule

// File: tb/tb_smi_transaction_responder.sv
// Directed bench: frames driven by a sender task, expected responses queued and checked by a monitor.
module tb_smi_transaction_responder;

  localparam int DW = 64;

  typedef struct packed {
    logic [7:0]    eofc;
    logic [DW-1:0] dat;
  } resp_t;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          req_rdy = 1'b0;
  logic [7:0]    req_eofc = 8'h00;
  logic [DW-1:0] req_dat = '0;
  logic          req_stop;
  logic          resp_rdy;
  logic [7:0]    resp_eofc;
  logic [DW-1:0] resp_dat;
  logic          resp_stop = 1'b0;

  resp_t       exp_q[$];
  logic [7:0]  fq_eof[$];
  logic [63:0] fq_dat[$];
  int          pop_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          mon_pops = 0;
  int          cyc = 0;
  bit          toggle_en = 1'b0;
  bit          hold_vld = 1'b0;
  resp_t       hold;

  always #5 clk = ~clk;

  smi_transaction_responder dut (
    .clk            (clk),
    .srst           (srst),
    .smiReqInReady  (req_rdy),
    .smiReqInEofc   (req_eofc),
    .smiReqInData   (req_dat),
    .smiReqInStop   (req_stop),
    .smiRespOutReady(resp_rdy),
    .smiRespOutEofc (resp_eofc),
    .smiRespOutData (resp_dat),
    .smiRespOutStop (resp_stop)
  );

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    resp_stop = toggle_en ? ~resp_stop : 1'b0;
  end

  // Monitor: pops one expected flit per response transfer, checks held data while stalled.
  always @(negedge clk) begin
    resp_t e;
    if (!srst && resp_rdy) begin
      if (hold_vld) begin
        total++;
        if ({resp_eofc, resp_dat} !== hold) begin
          bad++;
          $display("FAIL stall_hold got=%h want=%h", {resp_eofc, resp_dat}, hold);
        end
      end
      if (!resp_stop) begin
        hold_vld = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected got eofc=%0d dat=%h want=none", resp_eofc, resp_dat);
        end else begin
          e = exp_q.pop_front();
          if (resp_eofc !== e.eofc || resp_dat !== e.dat) begin
            bad++;
            $display("FAIL resp got eofc=%0d dat=%h want eofc=%0d dat=%h",
                     resp_eofc, resp_dat, e.eofc, e.dat);
          end
        end
        mon_pops++;
        pop_cyc.push_back(cyc);
      end else begin
        hold_vld = 1'b1;
        hold     = {resp_eofc, resp_dat};
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "global timeout");
  end

  function automatic logic [63:0] hdr(input logic [7:0] code, input logic [7:0] len,
                                      input logic [31:0] tag);
    return {tag, 16'h0000, len, code};
  endfunction

  function automatic logic [63:0] wdat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  function automatic logic [63:0] aflit(input int addr);
    return 64'(addr) << 3;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic add_flit(input logic [7:0] eofc, input logic [63:0] dat);
    fq_eof.push_back(eofc);
    fq_dat.push_back(dat);
  endtask

  task automatic push_exp(input logic [7:0] eofc, input logic [63:0] dat);
    resp_t r;
    r.eofc = eofc;
    r.dat  = dat;
    exp_q.push_back(r);
  endtask

  task automatic send_frame();
    int n;
    for (int i = 0; i < fq_dat.size(); i++) begin
      @(negedge clk);
      req_rdy  = 1'b1;
      req_eofc = fq_eof[i];
      req_dat  = fq_dat[i];
      n = 0;
      while (req_stop && n < 500) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (n >= 500) begin
        bad++;
        $display("FAIL req_accept_timeout got=stalled want=accepted flit=%0d", i);
      end
      @(posedge clk);
    end
    @(negedge clk);
    req_rdy  = 1'b0;
    req_eofc = 8'h00;
    fq_eof.delete();
    fq_dat.delete();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout got=%0d pending want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic read_req(input int addr, input logic [7:0] len, input logic [31:0] tag);
    add_flit(8'd0, hdr(8'h01, len, tag));
    add_flit(8'd8, aflit(addr));
  endtask

  initial begin
    int target;
    int n;
    repeat (3) @(negedge clk);
    check("rst_resp_ready", 64'(resp_rdy), 64'd0);
    check("rst_resp_eofc", 64'(resp_eofc), 64'd0);
    check("rst_resp_data", resp_dat, 64'd0);
    check("rst_req_stop", 64'(req_stop), 64'd1);
    srst = 1'b0;
    @(negedge clk);
    check("req_stop_after_rst", 64'(req_stop), 64'd0);

    // Write LEN=2 at 0x10.
    add_flit(8'd0, hdr(8'h02, 8'd2, 32'h0400_0007));
    add_flit(8'd0, aflit(16));
    add_flit(8'd0, 64'hA5A5_A5A5_A5A5_A5A5);
    add_flit(8'd8, 64'h5A5A_5A5A_5A5A_5A5A);
    push_exp(8'd8, hdr(8'h00, 8'd2, 32'h0400_0007));
    send_frame();
    wait_drain("write2");

    // Read it back with no stalls; header and words must be back-to-back.
    pop_cyc.delete();
    read_req(16, 8'd2, 32'h0400_0011);
    push_exp(8'd0, hdr(8'h00, 8'd2, 32'h0400_0011));
    push_exp(8'd0, 64'hA5A5_A5A5_A5A5_A5A5);
    push_exp(8'd8, 64'h5A5A_5A5A_5A5A_5A5A);
    send_frame();
    wait_drain("read2");
    check("read2_pops", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      check("read2_gap_hdr_w0", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      check("read2_gap_w0_w1", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end

    // Fill 16 words at 0x20, then read them with a toggling stall.
    add_flit(8'd0, hdr(8'h02, 8'd16, 32'h0800_0001));
    add_flit(8'd0, aflit(32));
    for (int i = 0; i < 16; i++) add_flit((i == 15) ? 8'd8 : 8'd0, wdat(i));
    push_exp(8'd8, hdr(8'h00, 8'd16, 32'h0800_0001));
    send_frame();
    wait_drain("write16");

    toggle_en = 1'b1;
    read_req(32, 8'd16, 32'h0800_0002);
    push_exp(8'd0, hdr(8'h00, 8'd16, 32'h0800_0002));
    for (int i = 0; i < 16; i++) push_exp((i == 15) ? 8'd8 : 8'd0, wdat(i));
    send_frame();
    wait_drain("read16_stall");
    toggle_en = 1'b0;

    // Bad opcode on a 3-flit frame.
    add_flit(8'd0, hdr(8'h07, 8'd1, 32'h0C00_0003));
    add_flit(8'd0, aflit(0));
    add_flit(8'd8, 64'hFFFF_0000_FFFF_0000);
    push_exp(8'd8, hdr(8'h01, 8'd1, 32'h0C00_0003));
    send_frame();
    wait_drain("bad_opcode");

    // Top-of-memory: LEN=2 at 1022 fits, LEN=4 does not and must leave RAM untouched.
    add_flit(8'd0, hdr(8'h02, 8'd2, 32'h1000_0001));
    add_flit(8'd0, aflit(1022));
    add_flit(8'd0, 64'h1111_1111_1111_1111);
    add_flit(8'd8, 64'h2222_2222_2222_2222);
    push_exp(8'd8, hdr(8'h00, 8'd2, 32'h1000_0001));
    send_frame();
    wait_drain("write_top");

    add_flit(8'd0, hdr(8'h02, 8'd4, 32'h1000_0002));
    add_flit(8'd0, aflit(1022));
    for (int i = 0; i < 4; i++) add_flit((i == 3) ? 8'd8 : 8'd0, 64'hDEAD_BEEF_0000_0000 | 64'(i));
    push_exp(8'd8, hdr(8'h02, 8'd4, 32'h1000_0002));
    send_frame();
    wait_drain("write_range");

    read_req(1022, 8'd2, 32'h1000_0003);
    push_exp(8'd0, hdr(8'h00, 8'd2, 32'h1000_0003));
    push_exp(8'd0, 64'h1111_1111_1111_1111);
    push_exp(8'd8, 64'h2222_2222_2222_2222);
    send_frame();
    wait_drain("read_top");

    // Short write: LEN=3 but only 2 data flits.
    add_flit(8'd0, hdr(8'h02, 8'd3, 32'h1400_0001));
    add_flit(8'd0, aflit(64));
    add_flit(8'd0, 64'h0123_4567_89AB_CDEF);
    add_flit(8'd8, 64'hFEDC_BA98_7654_3210);
    push_exp(8'd8, hdr(8'h03, 8'd3, 32'h1400_0001));
    send_frame();
    wait_drain("write_short");

    read_req(64, 8'd2, 32'h1400_0002);
    push_exp(8'd0, hdr(8'h00, 8'd2, 32'h1400_0002));
    push_exp(8'd0, 64'h0123_4567_89AB_CDEF);
    push_exp(8'd8, 64'hFEDC_BA98_7654_3210);
    send_frame();
    wait_drain("read_short");

    // LEN=0 read and an end-of-frame on the header.
    read_req(0, 8'd0, 32'h1800_0001);
    push_exp(8'd8, hdr(8'h02, 8'd0, 32'h1800_0001));
    send_frame();
    wait_drain("read_len0");

    add_flit(8'd8, hdr(8'h01, 8'd1, 32'h1800_0002));
    push_exp(8'd8, hdr(8'h03, 8'd1, 32'h1800_0002));
    send_frame();
    wait_drain("hdr_eof");

    // Reset in the middle of a read burst.
    read_req(32, 8'd8, 32'h1C00_0001);
    push_exp(8'd0, hdr(8'h00, 8'd8, 32'h1C00_0001));
    for (int i = 0; i < 8; i++) push_exp((i == 7) ? 8'd8 : 8'd0, wdat(i));
    target = mon_pops + 4;
    send_frame();
    n = 0;
    while (mon_pops < target && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midrst_reached_word3", 64'(mon_pops >= target), 64'd1);
    @(posedge clk);
    #1;
    srst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_resp_ready", 64'(resp_rdy), 64'd0);
    check("midrst_resp_eofc", 64'(resp_eofc), 64'd0);
    check("midrst_req_stop", 64'(req_stop), 64'd1);
    srst = 1'b0;
    @(negedge clk);
    check("midrst_req_stop_release", 64'(req_stop), 64'd0);

    read_req(16, 8'd2, 32'h1C00_0002);
    push_exp(8'd0, hdr(8'h00, 8'd2, 32'h1C00_0002));
    push_exp(8'd0, 64'hA5A5_A5A5_A5A5_A5A5);
    push_exp(8'd8, 64'h5A5A_5A5A_5A5A_5A5A);
    send_frame();
    wait_drain("read_after_rst");

    repeat (5) @(negedge clk);
    check("idle_resp_ready", 64'(resp_rdy), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
